// File: rtl/mult_acc_window_pkg.sv
// mult_acc_window_pkg: shared widths and the signed narrowing saturate helper
package mult_acc_window_pkg;

    localparam int WIDTH_DATA_OUT = 10;
    localparam int DEF_DATA_W     = 2 * WIDTH_DATA_OUT;
    localparam int DEF_ACC_W      = 32;
    localparam int DEF_OUT_W      = 20;
    localparam int DEF_LEN        = 9;

    typedef struct packed {
        logic signed [DEF_OUT_W-1:0] value;
        logic                        ovf;
    } sat_res_t;

    // Clamp an accumulator-width value into the output width and flag overflow
    function automatic sat_res_t sat_narrow(input logic signed [DEF_ACC_W-1:0] v);
        sat_res_t r;
        logic [DEF_ACC_W-DEF_OUT_W:0] hi;
        hi      = v[DEF_ACC_W-1:DEF_OUT_W-1];
        r.ovf   = !((&hi) || !(|hi));
        r.value = !r.ovf ? v[DEF_OUT_W-1:0]
                : v[DEF_ACC_W-1] ? {1'b1, {(DEF_OUT_W-1){1'b0}}}
                : {1'b0, {(DEF_OUT_W-1){1'b1}}};
        return r;
    endfunction

endpackage

// File: rtl/mult_acc_window_sat_narrow.sv
// mult_acc_window_sat_narrow: combinational signed clamp from IN_W to OUT_W with overflow flag
module mult_acc_window_sat_narrow #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 20
) (
    input  logic [IN_W-1:0]  in_i,
    output logic [OUT_W-1:0] out_o,
    output logic             ovf_o
);

    localparam logic [OUT_W-1:0] MAX_V = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W-1){1'b0}}};

    logic [IN_W-OUT_W:0] hi;

    // In range only when every bit above the output sign bit copies it
    always_comb begin
        hi    = in_i[IN_W-1:OUT_W-1];
        ovf_o = !((&hi) || !(|hi));
        out_o = !ovf_o ? in_i[OUT_W-1:0] : in_i[IN_W-1] ? MIN_V : MAX_V;
    end

endmodule

// File: rtl/mult_acc_window.sv
// mult_acc_window: windowed signed product accumulator with bias, saturation and a one-entry output register
module mult_acc_window
    import mult_acc_window_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int LEN    = DEF_LEN
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic [ACC_W-1:0]  bias_in,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_sat,
    output logic [7:0]        win_cnt
);

    localparam logic [7:0] LAST = 8'(LEN - 1);

    logic [7:0]       cnt_q, cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic             out_sat_q, out_sat_d;
    logic             last, accept, load;
    logic [ACC_W-1:0] in_sext, sum;
    logic [OUT_W-1:0] sat_val;
    logic             sat_ovf;

    // Bias replaces the running sum on the first beat, so LEN==1 still gets it
    always_comb begin
        last     = cnt_q == LAST;
        in_ready = clr || !(last && out_valid_q && !out_ready);
        accept   = in_valid && in_ready && !clr;
        load     = accept && last;
        in_sext  = {{(ACC_W-DATA_W){in_data[DATA_W-1]}}, in_data};
        sum      = (cnt_q == 8'd0 ? bias_in : acc_q) + in_sext;
    end

    mult_acc_window_sat_narrow #(
        .IN_W  (ACC_W),
        .OUT_W (OUT_W)
    ) u_sat (
        .in_i  (sum),
        .out_o (sat_val),
        .ovf_o (sat_ovf)
    );

    // Next state: clr dominates, a completed window loads the output register
    always_comb begin
        cnt_d       = clr ? 8'd0 : accept ? (last ? 8'd0 : cnt_q + 8'd1) : cnt_q;
        acc_d       = clr ? '0 : accept ? (last ? '0 : sum) : acc_q;
        out_valid_d = clr ? 1'b0 : load ? 1'b1 : (out_valid_q && out_ready) ? 1'b0 : out_valid_q;
        out_data_d  = clr ? '0 : load ? sat_val : out_data_q;
        out_sat_d   = clr ? 1'b0 : load ? sat_ovf : out_sat_q;
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign win_cnt   = cnt_q;

endmodule
